// File: rtl/uart_byte_receiver.sv
// UART 8N1 byte receiver with a small first-word-fall-through receive FIFO.
// Sticky frame/overrun error flags; an error set in the same cycle as clr_err still latches.
module uart_byte_receiver #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rd,
  input  logic       clr_err,
  output logic [7:0] dout,
  output logic       ready,
  output logic       full,
  output logic       frame_err,
  output logic       overrun
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [TW-1:0] BIT_END  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_END = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [AW-1:0] PTR_LAST = AW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t         state_q, state_d;
  logic           rx_meta_q, rx_meta_d;
  logic           rxs_q, rxs_d;
  logic           rxs_prev_q, rxs_prev_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     shift_q, shift_d;
  logic [7:0]     mem_q [FIFO_DEPTH];
  logic [7:0]     mem_d [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           frame_err_q, frame_err_d;
  logic           overrun_q, overrun_d;

  logic fall, half_done, bit_done;
  logic byte_push, frame_evt, push_ok, pop_ok, drop;

  assign fall      = rxs_prev_q & ~rxs_q;
  assign half_done = (timer_q == HALF_END);
  assign bit_done  = (timer_q == BIT_END);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rx_meta_q   <= 1'b1;
      rxs_q       <= 1'b1;
      rxs_prev_q  <= 1'b1;
      timer_q     <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      mem_q       <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rx_meta_q   <= rx_meta_d;
      rxs_q       <= rxs_d;
      rxs_prev_q  <= rxs_prev_d;
      timer_q     <= timer_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (fall) state_d = START;
      START:   if (half_done) state_d = rxs_q ? IDLE : DATA;
      DATA:    if (bit_done && bit_cnt_q == 3'd7) state_d = STOP;
      STOP:    if (bit_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bit timer restarts at every sample point, so it never exceeds CLKS_PER_BIT-1.
  always_comb begin
    rx_meta_d  = rx;
    rxs_d      = rx_meta_q;
    rxs_prev_d = rxs_q;
    timer_d    = timer_q + TW'(1);
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    byte_push  = 1'b0;
    frame_evt  = 1'b0;
    case (state_q)
      IDLE: timer_d = '0;
      START: if (half_done) timer_d = '0;
      DATA: begin
        if (bit_done) begin
          timer_d   = '0;
          shift_d   = {rxs_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
        end
      end
      STOP: begin
        if (bit_done) begin
          timer_d   = '0;
          byte_push = rxs_q;
          frame_evt = ~rxs_q;
        end
      end
      default: timer_d = '0;
    endcase
  end

  // A push into a full FIFO is only accepted when the head is popped in the same cycle.
  always_comb begin
    pop_ok   = rd & (count_q != '0);
    push_ok  = byte_push & (~full | rd);
    drop     = byte_push & full & ~rd;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = shift_q;
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + AW'(1);
    end
    if (push_ok && !pop_ok) begin
      count_d = count_q + CW'(1);
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - CW'(1);
    end
    frame_err_d = frame_evt | (frame_err_q & ~clr_err);
    overrun_d   = drop | (overrun_q & ~clr_err);
  end

  always_comb begin
    ready     = (count_q != '0);
    full      = (count_q == CNT_FULL);
    dout      = ready ? mem_q[rd_ptr_q] : 8'h00;
    frame_err = frame_err_q;
    overrun   = overrun_q;
  end

endmodule

// File: tb/tb_uart_byte_receiver.sv
// Directed and randomized bench for uart_byte_receiver (CLKS_PER_BIT=16, FIFO_DEPTH=4),
// scored against a queue-based model of the receive FIFO and error flags.
module tb_uart_byte_receiver;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst, rx, rd, clr_err;
  logic [7:0] dout;
  logic       ready, full, frame_err, overrun;

  int errors = 0;
  int checks = 0;

  logic [7:0] mq[$];
  logic       mFe = 1'b0;
  logic       mOv = 1'b0;

  uart_byte_receiver #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rx(rx), .rd(rd), .clr_err(clr_err),
    .dout(dout), .ready(ready), .full(full), .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic compareAll(input string pre);
    checkOutput({pre, ".ready"}, {7'd0, ready}, {7'd0, mq.size() != 0});
    checkOutput({pre, ".full"}, {7'd0, full}, {7'd0, mq.size() == DEPTH});
    checkOutput({pre, ".frame_err"}, {7'd0, frame_err}, {7'd0, mFe});
    checkOutput({pre, ".overrun"}, {7'd0, overrun}, {7'd0, mOv});
    if (mq.size() != 0) checkOutput({pre, ".dout"}, dout, mq[0]);
  endtask

  // One full 10-bit frame, 160 cycles; the stop sample lands on the 155th rising edge.
  task automatic applyStimulus(input logic [7:0] data, input logic stopBit,
                               input logic rdAtPush, input logic checkTiming);
    logic [9:0] bits;
    logic       wasFull;
    bits = {stopBit, data, 1'b0};
    for (int c = 0; c < 10 * CPB; c++) begin
      if (checkTiming && c == 154) checkOutput("t154.ready", {7'd0, ready}, 8'd0);
      if (checkTiming && c == 155) begin
        checkOutput("t155.ready", {7'd0, ready}, 8'd1);
        checkOutput("t155.dout", dout, data);
      end
      rx = bits[c / CPB];
      rd = rdAtPush && (c == 154);
      @(negedge clk);
    end
    rx = 1'b1;
    rd = 1'b0;
    wasFull = (mq.size() == DEPTH);
    if (rdAtPush && mq.size() != 0) void'(mq.pop_front());
    if (!stopBit) mFe = 1'b1;
    else if (wasFull && !rdAtPush) mOv = 1'b1;
    else mq.push_back(data);
  endtask

  task automatic popByte(input string pre);
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    if (mq.size() != 0) void'(mq.pop_front());
    compareAll(pre);
  endtask

  task automatic pulseClr();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    mFe = 1'b0;
    mOv = 1'b0;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [7:0] d;
    logic [9:0] pbits;
    rst = 1'b0; rx = 1'b1; rd = 1'b0; clr_err = 1'b0;
    #1 rst = 1'b1;
    #1;
    checkOutput("rst.ready", {7'd0, ready}, 8'd0);
    checkOutput("rst.full", {7'd0, full}, 8'd0);
    checkOutput("rst.frame_err", {7'd0, frame_err}, 8'd0);
    checkOutput("rst.overrun", {7'd0, overrun}, 8'd0);
    checkOutput("rst.dout", dout, 8'h00);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(5);

    applyStimulus(8'hA5, 1'b1, 1'b0, 1'b1);
    compareAll("a5");
    popByte("a5.pop");

    rx = 1'b0;
    repeat (5) @(negedge clk);
    idle(40);
    compareAll("glitch");

    applyStimulus(8'h3C, 1'b0, 1'b0, 1'b0);
    compareAll("badstop");
    pulseClr();
    compareAll("badstop.clr");

    for (int i = 1; i <= 5; i++) begin
      applyStimulus(8'(i), 1'b1, 1'b0, 1'b0);
      compareAll($sformatf("fill%0d", i));
    end
    for (int i = 0; i < 4; i++) popByte($sformatf("drain%0d", i));
    pulseClr();
    compareAll("drain.clr");

    applyStimulus(8'h42, 1'b1, 1'b1, 1'b0);
    compareAll("emptyrd");
    popByte("emptyrd.pop");
    popByte("emptyrd.popempty");

    for (int i = 0; i < 4; i++) applyStimulus(8'($urandom), 1'b1, 1'b0, 1'b0);
    compareAll("pre77");
    applyStimulus(8'h77, 1'b1, 1'b1, 1'b0);
    compareAll("push77");
    for (int i = 0; i < 3; i++) popByte($sformatf("p77_%0d", i));
    checkOutput("head77", dout, 8'h77);
    popByte("p77_last");

    pbits = {1'b1, 8'h96, 1'b0};
    for (int c = 0; c < 60; c++) begin
      rx = pbits[c / CPB];
      @(negedge clk);
    end
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    mq.delete();
    mFe = 1'b0;
    mOv = 1'b0;
    idle(40);
    compareAll("midrst");
    applyStimulus(8'h5A, 1'b1, 1'b0, 1'b0);
    compareAll("5a");
    popByte("5a.pop");

    for (int i = 0; i < 10; i++) begin
      d = 8'($urandom);
      applyStimulus(d, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 1'b0);
      compareAll($sformatf("rnd%0d", i));
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) popByte($sformatf("rnd%0d.pop%0d", i, k));
      if ($urandom_range(0, 3) == 0) begin
        pulseClr();
        compareAll($sformatf("rnd%0d.clr", i));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
